dcr_mem_wb_stage: RTL and testbench
===================================

// Module: dcr_mem_wb_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register; producer of the writeback/bypass bus consumed by decode/WB.
//  Sends loads/stores to data memory over a req/ack handshake and stalls the pipeline via the PMCU until ack.
//  Registers ALU result, load data, write address and controls into the WB stage.
//  Also drives the MEM-stage ALU bypass and load-data bypass toward decode.
// PARAMETERS
//  ADDR_W   8   data-memory word address width; DMemAddrOut = ALUResultInMEM[ADDR_W-1:0]
//  TIMEOUT  15  max cycles in REQ without ack before bus error (1..255)
// PORTS
//  clk                   in   1       clock
//  rst                   in   1       reset; synchronous, active-high
//  clken                 in   1       pipeline advance enable from PMCU
//  MemReadInMEM          in   1       instr in MEM is a load
//  MemWriteInMEM         in   1       instr in MEM is a store
//  RegWriteInMEM         in   1       instr writes register file
//  ALUResultInMEM        in   32      ALU result / effective address
//  StoreDataInMEM        in   32      store data (R[rt])
//  WriteAddrInMEM        in   5       destination register
//  DMemReqOut            out  1       memory request, held until ack
//  DMemWeOut             out  1       1 = write, 0 = read; valid with req
//  DMemAddrOut           out  ADDR_W  word address; stable while req
//  DMemWrDataOut         out  32      write data; stable while req
//  DMemAckIn             in   1       access complete (read data valid same cycle)
//  DMemRdDataIn          in   32      read data
//  ALUDataOutID          out  32      WB: registered ALU result
//  MemDataOutID          out  32      WB: registered load data
//  WriteAddrOutID        out  5       WB: registered destination
//  RegWriteOutID         out  1       WB: register-file write enable
//  MemReadOutID          out  1       WB: select MemData over ALUData
//  MEMALUBypassDataOutID out  32      comb = ALUResultInMEM
//  MEMMEMBypassDataOutID out  32      load data hold register
//  WriteAddrOutPMCU      out  5       comb = WriteAddrInMEM (hazard detect)
//  RegWriteOutPMCU       out  1       comb = RegWriteInMEM
//  StallOutPMCU          out  1       1 = freeze IF..MEM this cycle
//  BusErrOutPMCU         out  1       sticky ack-timeout flag
// BEHAVIOUR
//  - Reset: state IDLE, timeout count 0, all registered outputs 0, DMemReqOut 0, BusErrOutPMCU 0; takes effect mid-REQ (req drops next edge; late ack ignored).
//  - memop = MemReadInMEM | MemWriteInMEM. StallOutPMCU = memop & (state != DONE) (comb).
//  - FSM: IDLE -> REQ if memop. REQ: DMemReqOut=1, DMemWeOut=MemWriteInMEM; on DMemAckIn capture
//    DMemRdDataIn (loads only) into hold reg, -> DONE. On count==TIMEOUT without ack: hold reg=0,
//    BusErrOutPMCU<=1, -> DONE. DONE -> IDLE when clken, else stay.
//  - FSM ignores clken except DONE exit; ack outside REQ ignored. Min load/store cost: 2 stall cycles (ack in first REQ cycle).
//  - Timeout counter: cleared entering REQ, +1 per REQ cycle without ack; width $clog2(TIMEOUT+1).
//  - WB register, clken & !stall: load ALUResultInMEM, WriteAddrInMEM, RegWriteInMEM, MemReadInMEM,
//    MemDataOutID<=hold reg if load else 0. clken & stall: bubble (RegWriteOutID=0, MemReadOutID=0,
//    data held). !clken: all hold.
//  - Upper ALUResultInMEM bits above ADDR_W ignored; no alignment check (word addressed).
// STRUCTURE
//  - dcr_pkg: typedef enum logic[1:0] {MEM_IDLE, MEM_REQ, MEM_DONE} mem_state_t; DCR_TIMEOUT_DEF=15.
//  - Sub-module dcr_dmem_if: FSM, timeout counter, hold reg, DMem* drive, stall/error; top keeps WB register and bypass wiring.
// TESTING
//  - ALU op (RegWrite=1, ALU=32'h0000_0042, addr 5'd9), clken=1 -> next cycle ALUDataOutID=0x42, WriteAddrOutID=9, RegWriteOutID=1, stall never high.
//  - Load addr 0x1_0013, ack+rdata 0xCAFE_F00D in first REQ cycle -> DMemAddrOut=8'h13; stall 2 cycles; then MemDataOutID=0xCAFEF00D, MemReadOutID=1; bypass=0xCAFEF00D from DONE on.
//  - Store data 0x1234_5678, ack after 4 REQ cycles -> req/we/addr/data stable all 4; RegWriteOutID=0 during stall; stall drops in DONE.
//  - No ack, TIMEOUT=15 -> 15 REQ cycles, BusErrOutPMCU=1 sticky, MemDataOutID=0, pipeline advances.
//  - rst in 2nd REQ cycle, ack next cycle -> state IDLE, req=0, outputs 0, no capture.
//  - Load done with clken=0 for 3 cycles -> stays DONE, stall=0, WB outputs hold; capture on clken.

Source files
------------

// File: rtl/dcr_pkg.sv
// Shared types and defaults for the MEM/WB stage and its data-memory handshake.
package dcr_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_REQ,
        MEM_DONE
    } mem_state_t;

    localparam int unsigned DCR_TIMEOUT_DEF = 15;

endpackage

// File: rtl/dcr_mem_wb_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface dcr_mem_wb_stage_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              DMemReqOut;
    logic              DMemWeOut;
    logic [ADDR_W-1:0] DMemAddrOut;
    logic [31:0]       DMemWrDataOut;
    logic              DMemAckIn;
    logic [31:0]       DMemRdDataIn;

    modport master (
        output DMemReqOut,
        output DMemWeOut,
        output DMemAddrOut,
        output DMemWrDataOut,
        input  DMemAckIn,
        input  DMemRdDataIn
    );

    modport slave (
        input  DMemReqOut,
        input  DMemWeOut,
        input  DMemAddrOut,
        input  DMemWrDataOut,
        output DMemAckIn,
        output DMemRdDataIn
    );

endinterface

// File: rtl/dcr_dmem_if.sv
// Data-memory access FSM: issues req until ack or timeout, holds load data, drives stall/bus error.
module dcr_dmem_if
    import dcr_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = DCR_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clken,
    input  logic               memread,
    input  logic               memwrite,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [31:0]        wrdata,
    dcr_mem_wb_stage_if.master dmem,
    output logic [31:0]        hold,
    output logic               stall,
    output logic               buserr
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    mem_state_t        state_q;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_inc;
    logic              req_q;
    logic              we_q;
    logic [31:0]       hold_q;
    logic              buserr_q;
    logic              memop;

    assign memop   = memread | memwrite;
    assign cnt_inc = cnt_q + CntW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MEM_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            hold_q   <= '0;
            buserr_q <= 1'b0;
        end else begin
            unique case (state_q)
                MEM_IDLE: begin
                    if (memop) begin
                        state_q <= MEM_REQ;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        we_q    <= memwrite;
                    end
                end
                MEM_REQ: begin
                    if (dmem.DMemAckIn) begin
                        if (memread) hold_q <= dmem.DMemRdDataIn;
                        state_q <= MEM_DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                        // Timeout fires at the end of the TIMEOUT-th unacknowledged REQ cycle.
                        if (cnt_inc == CntW'(TIMEOUT)) begin
                            hold_q   <= '0;
                            buserr_q <= 1'b1;
                            state_q  <= MEM_DONE;
                            req_q    <= 1'b0;
                            we_q     <= 1'b0;
                        end
                    end
                end
                MEM_DONE: begin
                    if (clken) state_q <= MEM_IDLE;
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    assign dmem.DMemReqOut    = req_q;
    assign dmem.DMemWeOut     = we_q;
    assign dmem.DMemAddrOut   = addr;
    assign dmem.DMemWrDataOut = wrdata;

    assign stall  = memop & (state_q != MEM_DONE);
    assign hold   = hold_q;
    assign buserr = buserr_q;

endmodule

// File: rtl/dcr_mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register; drives the writeback and MEM bypass buses toward decode.
module dcr_mem_wb_stage
    import dcr_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = DCR_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clken,
    input  logic               MemReadInMEM,
    input  logic               MemWriteInMEM,
    input  logic               RegWriteInMEM,
    input  logic [31:0]        ALUResultInMEM,
    input  logic [31:0]        StoreDataInMEM,
    input  logic [4:0]         WriteAddrInMEM,
    dcr_mem_wb_stage_if.master dmem,
    output logic [31:0]        ALUDataOutID,
    output logic [31:0]        MemDataOutID,
    output logic [4:0]         WriteAddrOutID,
    output logic               RegWriteOutID,
    output logic               MemReadOutID,
    output logic [31:0]        MEMALUBypassDataOutID,
    output logic [31:0]        MEMMEMBypassDataOutID,
    output logic [4:0]         WriteAddrOutPMCU,
    output logic               RegWriteOutPMCU,
    output logic               StallOutPMCU,
    output logic               BusErrOutPMCU
);

    logic [31:0] hold;
    logic        stall;

    dcr_dmem_if #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_dmem (
        .clk      (clk),
        .rst      (rst),
        .clken    (clken),
        .memread  (MemReadInMEM),
        .memwrite (MemWriteInMEM),
        .addr     (ALUResultInMEM[ADDR_W-1:0]),
        .wrdata   (StoreDataInMEM),
        .dmem     (dmem),
        .hold     (hold),
        .stall    (stall),
        .buserr   (BusErrOutPMCU)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ALUDataOutID   <= '0;
            MemDataOutID   <= '0;
            WriteAddrOutID <= '0;
            RegWriteOutID  <= 1'b0;
            MemReadOutID   <= 1'b0;
        end else if (clken) begin
            if (!stall) begin
                ALUDataOutID   <= ALUResultInMEM;
                MemDataOutID   <= MemReadInMEM ? hold : 32'h0;
                WriteAddrOutID <= WriteAddrInMEM;
                RegWriteOutID  <= RegWriteInMEM;
                MemReadOutID   <= MemReadInMEM;
            end else begin
                // Stalled memory op: push a bubble into WB, keep data fields.
                RegWriteOutID <= 1'b0;
                MemReadOutID  <= 1'b0;
            end
        end
    end

    assign MEMALUBypassDataOutID = ALUResultInMEM;
    assign MEMMEMBypassDataOutID = hold;
    assign WriteAddrOutPMCU      = WriteAddrInMEM;
    assign RegWriteOutPMCU       = RegWriteInMEM;
    assign StallOutPMCU          = stall;

endmodule

// File: tb/tb_dcr_mem_wb_stage.sv
// Directed bench for dcr_mem_wb_stage: ALU pass-through, load, store, timeout, reset, clken hold.
module tb_dcr_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        clken;
    logic        MemReadInMEM;
    logic        MemWriteInMEM;
    logic        RegWriteInMEM;
    logic [31:0] ALUResultInMEM;
    logic [31:0] StoreDataInMEM;
    logic [4:0]  WriteAddrInMEM;
    logic [31:0] ALUDataOutID;
    logic [31:0] MemDataOutID;
    logic [4:0]  WriteAddrOutID;
    logic        RegWriteOutID;
    logic        MemReadOutID;
    logic [31:0] MEMALUBypassDataOutID;
    logic [31:0] MEMMEMBypassDataOutID;
    logic [4:0]  WriteAddrOutPMCU;
    logic        RegWriteOutPMCU;
    logic        StallOutPMCU;
    logic        BusErrOutPMCU;

    int checks   = 0;
    int failures = 0;

    dcr_mem_wb_stage_if #(.ADDR_W(8)) dmem ();

    dcr_mem_wb_stage #(
        .ADDR_W  (8),
        .TIMEOUT (15)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .clken                 (clken),
        .MemReadInMEM          (MemReadInMEM),
        .MemWriteInMEM         (MemWriteInMEM),
        .RegWriteInMEM         (RegWriteInMEM),
        .ALUResultInMEM        (ALUResultInMEM),
        .StoreDataInMEM        (StoreDataInMEM),
        .WriteAddrInMEM        (WriteAddrInMEM),
        .dmem                  (dmem),
        .ALUDataOutID          (ALUDataOutID),
        .MemDataOutID          (MemDataOutID),
        .WriteAddrOutID        (WriteAddrOutID),
        .RegWriteOutID         (RegWriteOutID),
        .MemReadOutID          (MemReadOutID),
        .MEMALUBypassDataOutID (MEMALUBypassDataOutID),
        .MEMMEMBypassDataOutID (MEMMEMBypassDataOutID),
        .WriteAddrOutPMCU      (WriteAddrOutPMCU),
        .RegWriteOutPMCU       (RegWriteOutPMCU),
        .StallOutPMCU          (StallOutPMCU),
        .BusErrOutPMCU         (BusErrOutPMCU)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic rw,
                          input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] wa);
        MemReadInMEM   = rd;
        MemWriteInMEM  = wr;
        RegWriteInMEM  = rw;
        ALUResultInMEM = alu;
        StoreDataInMEM = sd;
        WriteAddrInMEM = wa;
    endtask

    initial begin
        rst   = 1'b1;
        clken = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        dmem.DMemAckIn    = 1'b0;
        dmem.DMemRdDataIn = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_alu",    ALUDataOutID, 32'h0);
        check_eq("rst_mdata",  MemDataOutID, 32'h0);
        check_eq("rst_rw",     {31'h0, RegWriteOutID}, 32'h0);
        check_eq("rst_req",    {31'h0, dmem.DMemReqOut}, 32'h0);
        check_eq("rst_buserr", {31'h0, BusErrOutPMCU}, 32'h0);
        check_eq("rst_stall",  {31'h0, StallOutPMCU}, 32'h0);

        // ALU op passes straight through to WB
        set_op(1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 5'd9);
        #1;
        check_eq("alu_stall",  {31'h0, StallOutPMCU}, 32'h0);
        check_eq("alu_byp",    MEMALUBypassDataOutID, 32'h42);
        check_eq("alu_pmcuwa", {27'h0, WriteAddrOutPMCU}, 32'd9);
        check_eq("alu_pmcurw", {31'h0, RegWriteOutPMCU}, 32'h1);
        tick();
        check_eq("alu_wb",     ALUDataOutID, 32'h42);
        check_eq("alu_wa",     {27'h0, WriteAddrOutID}, 32'd9);
        check_eq("alu_rw",     {31'h0, RegWriteOutID}, 32'h1);
        check_eq("alu_stall2", {31'h0, StallOutPMCU}, 32'h0);

        // Load acked in the first REQ cycle
        set_op(1'b1, 1'b0, 1'b1, 32'h0001_0013, 32'h0, 5'd3);
        #1;
        check_eq("ld_stall_idle", {31'h0, StallOutPMCU}, 32'h1);
        check_eq("ld_req_idle",   {31'h0, dmem.DMemReqOut}, 32'h0);
        tick();
        dmem.DMemAckIn    = 1'b1;
        dmem.DMemRdDataIn = 32'hCAFE_F00D;
        #1;
        check_eq("ld_req",      {31'h0, dmem.DMemReqOut}, 32'h1);
        check_eq("ld_we",       {31'h0, dmem.DMemWeOut}, 32'h0);
        check_eq("ld_addr",     {24'h0, dmem.DMemAddrOut}, 32'h13);
        check_eq("ld_stall_req", {31'h0, StallOutPMCU}, 32'h1);
        check_eq("ld_bubble",   {31'h0, RegWriteOutID}, 32'h0);
        tick();
        dmem.DMemAckIn = 1'b0;
        #1;
        check_eq("ld_stall_done", {31'h0, StallOutPMCU}, 32'h0);
        check_eq("ld_byp",        MEMMEMBypassDataOutID, 32'hCAFE_F00D);
        check_eq("ld_req_done",   {31'h0, dmem.DMemReqOut}, 32'h0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        check_eq("ld_mdata", MemDataOutID, 32'hCAFE_F00D);
        check_eq("ld_mr",    {31'h0, MemReadOutID}, 32'h1);
        check_eq("ld_rw",    {31'h0, RegWriteOutID}, 32'h1);
        check_eq("ld_wa",    {27'h0, WriteAddrOutID}, 32'd3);
        check_eq("ld_alu",   ALUDataOutID, 32'h0001_0013);

        // Store acked on the fourth REQ cycle
        set_op(1'b0, 1'b1, 1'b0, 32'h0000_00A5, 32'h1234_5678, 5'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem.DMemAckIn = (i == 3);
            #1;
            check_eq($sformatf("st_req%0d", i),   {31'h0, dmem.DMemReqOut}, 32'h1);
            check_eq($sformatf("st_we%0d", i),    {31'h0, dmem.DMemWeOut}, 32'h1);
            check_eq($sformatf("st_addr%0d", i),  {24'h0, dmem.DMemAddrOut}, 32'hA5);
            check_eq($sformatf("st_data%0d", i),  dmem.DMemWrDataOut, 32'h1234_5678);
            check_eq($sformatf("st_stall%0d", i), {31'h0, StallOutPMCU}, 32'h1);
            check_eq($sformatf("st_rw%0d", i),    {31'h0, RegWriteOutID}, 32'h0);
            tick();
        end
        dmem.DMemAckIn = 1'b0;
        #1;
        check_eq("st_stall_done", {31'h0, StallOutPMCU}, 32'h0);
        check_eq("st_req_done",   {31'h0, dmem.DMemReqOut}, 32'h0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        check_eq("st_mdata", MemDataOutID, 32'h0);
        check_eq("st_mr",    {31'h0, MemReadOutID}, 32'h0);
        check_eq("st_alu",   ALUDataOutID, 32'hA5);
        check_eq("st_hold",  MEMMEMBypassDataOutID, 32'hCAFE_F00D);

        // Load never acked: 15 REQ cycles then bus error
        set_op(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 5'd7);
        tick();
        for (int i = 0; i < 15; i++) begin
            #1;
            check_eq($sformatf("to_req%0d", i), {31'h0, dmem.DMemReqOut}, 32'h1);
            check_eq($sformatf("to_err%0d", i), {31'h0, BusErrOutPMCU}, 32'h0);
            tick();
        end
        #1;
        check_eq("to_req_done", {31'h0, dmem.DMemReqOut}, 32'h0);
        check_eq("to_err",      {31'h0, BusErrOutPMCU}, 32'h1);
        check_eq("to_stall",    {31'h0, StallOutPMCU}, 32'h0);
        check_eq("to_hold",     MEMMEMBypassDataOutID, 32'h0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        check_eq("to_mdata",  MemDataOutID, 32'h0);
        check_eq("to_mr",     {31'h0, MemReadOutID}, 32'h1);
        check_eq("to_wa",     {27'h0, WriteAddrOutID}, 32'd7);
        tick();
        check_eq("to_sticky", {31'h0, BusErrOutPMCU}, 32'h1);

        // Reset in second REQ cycle; ack arriving after reset is ignored
        set_op(1'b1, 1'b0, 1'b1, 32'h0000_0055, 32'h0, 5'd4);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("rr_req_before", {31'h0, dmem.DMemReqOut}, 32'h1);
        tick();
        rst = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        dmem.DMemAckIn    = 1'b1;
        dmem.DMemRdDataIn = 32'hDEAD_BEEF;
        #1;
        check_eq("rr_req",    {31'h0, dmem.DMemReqOut}, 32'h0);
        check_eq("rr_err",    {31'h0, BusErrOutPMCU}, 32'h0);
        check_eq("rr_alu",    ALUDataOutID, 32'h0);
        check_eq("rr_mdata",  MemDataOutID, 32'h0);
        check_eq("rr_rw",     {31'h0, RegWriteOutID}, 32'h0);
        check_eq("rr_hold",   MEMMEMBypassDataOutID, 32'h0);
        tick();
        dmem.DMemAckIn = 1'b0;
        #1;
        check_eq("rr_hold2",  MEMMEMBypassDataOutID, 32'h0);
        check_eq("rr_req2",   {31'h0, dmem.DMemReqOut}, 32'h0);

        // Load completes while clken is low for 3 cycles
        set_op(1'b1, 1'b0, 1'b1, 32'h0000_0077, 32'h0, 5'd12);
        tick();
        dmem.DMemAckIn    = 1'b1;
        dmem.DMemRdDataIn = 32'h0BAD_F00D;
        tick();
        dmem.DMemAckIn = 1'b0;
        clken          = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("ck_stall%0d", i), {31'h0, StallOutPMCU}, 32'h0);
            check_eq($sformatf("ck_req%0d", i),   {31'h0, dmem.DMemReqOut}, 32'h0);
            check_eq($sformatf("ck_alu%0d", i),   ALUDataOutID, 32'h0);
            check_eq($sformatf("ck_rw%0d", i),    {31'h0, RegWriteOutID}, 32'h0);
            tick();
        end
        clken = 1'b1;
        #1;
        check_eq("ck_stall_on", {31'h0, StallOutPMCU}, 32'h0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        check_eq("ck_mdata", MemDataOutID, 32'h0BAD_F00D);
        check_eq("ck_alu",   ALUDataOutID, 32'h77);
        check_eq("ck_wa",    {27'h0, WriteAddrOutID}, 32'd12);
        check_eq("ck_mr",    {31'h0, MemReadOutID}, 32'h1);
        check_eq("ck_rw",    {31'h0, RegWriteOutID}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
